// File: rtl/apb_master_bridge.sv
// APB initiator bridge: accepts single CPU requests on a valid/ready port,
// decodes them to one of NUM_SLAVES APB peripherals and runs one SETUP/ACCESS
// transfer. A PREADY timeout converts a dead slave into an error response.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while the bridge is idle.
// rsp_valid is a one-cycle strobe with no backpressure, qualifying
// rsp_rdata/rsp_err.
module apb_master_bridge #(
  parameter int          NUM_SLAVES  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic                    req_write,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic                    PENABLE,
  output logic [NUM_SLAVES-1:0]   PSEL,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]   PREADY,
  output logic [1:0]              o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_SLAVES-1:0] r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic [31:0]           r_paddr, w_paddr_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [31:0]           r_pwdata, w_pwdata_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]           r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;

  logic [3:0]            w_idx;
  logic                  w_hit;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic                  w_pready_sel;
  logic [31:0]           w_prdata_sel;

  // Address decode of the incoming request into a hit flag and a one-hot select
  always_comb begin
    w_idx = req_addr[15:12];
    w_hit = (req_addr[31:16] == BASE_ADDR[31:16]) && (int'(w_idx) < NUM_SLAVES);
    for (int k = 0; k < NUM_SLAVES; k++) begin
      w_onehot[k] = (int'(w_idx) == k);
    end
  end

  // Return path mux steered by the registered PSEL, so unselected slaves never leak in
  always_comb begin
    w_pready_sel = 1'b0;
    w_prdata_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_psel[k]) begin
        w_pready_sel = w_pready_sel | PREADY[k];
        w_prdata_sel = w_prdata_sel | PRDATA[32*k +: 32];
      end
    end
  end

  // Next-state and next-output logic; every output is computed here and registered
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_paddr_nxt     = r_paddr;
    w_pwrite_nxt    = r_pwrite;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_hit) begin
            // Bus fields only change on a real transfer so a miss leaves the bus untouched
            w_paddr_nxt   = req_addr;
            w_pwrite_nxt  = req_write;
            w_pwdata_nxt  = req_wdata;
            w_psel_nxt    = w_onehot;
            w_penable_nxt = 1'b0;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_SETUP;
          end else begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
            w_state_nxt     = S_RESP;
          end
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_pready_sel) begin
          w_psel_nxt      = '0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_pwrite ? 32'd0 : w_prdata_sel;
          w_state_nxt     = S_RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_psel_nxt      = '0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_state_nxt     = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a response
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state     <= S_IDLE;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign PADDR       = r_paddr;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;
  assign PENABLE     = r_penable;
  assign PSEL        = r_psel;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios followed by randomized
// requests, each checked against an expectation computed from the bridge's
// transfer rules (decode, wait states, timeout) and a response queue.
module tb_apb_master_bridge;

  localparam int          NS   = 4;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic            PCLK = 1'b0;
  logic            PRESET;
  logic            req_valid, req_ready, req_write;
  logic [31:0]     req_addr, req_wdata;
  logic            rsp_valid, rsp_err;
  logic [31:0]     rsp_rdata;
  logic [31:0]     PADDR, PWDATA;
  logic            PWRITE, PENABLE;
  logic [NS-1:0]   PSEL, pready;
  logic [32*NS-1:0] prdata_bus;
  logic [1:0]      dbg_state;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.NUM_SLAVES(NS), .BASE_ADDR(BASE), .TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA(prdata_bus), .PREADY(pready), .o_dbg_state(dbg_state)
  );

  // ---------------- slave models ----------------
  logic [31:0] prdata_v [NS];
  logic [3:0]  wait_cfg [NS];
  logic [NS-1:0] stuck;
  logic [NS-1:0] noise;
  int acc_s;

  always_comb begin
    for (int k = 0; k < NS; k++) prdata_bus[32*k +: 32] = prdata_v[k];
  end

  // Selected slave answers after wait_cfg not-ready ACCESS cycles; otherwise random noise
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      if (stuck[k])                 pready[k] = 1'b0;
      else if (PSEL[k] && PENABLE)  pready[k] = (acc_s == int'(wait_cfg[k]));
      else                          pready[k] = noise[k];
    end
  end

  always @(posedge PCLK or negedge PRESET) begin
    if (!PRESET)                  acc_s <= 0;
    else if (PSEL != 0 && PENABLE) acc_s <= acc_s + 1;
    else                          acc_s <= 0;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver + per-transfer check ----------------
  // Called just after a falling edge. Presents one request, observes it to its
  // response, then loads the follow-on request (nv) right after acceptance.
  task automatic run_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic nv, input logic [31:0] na, input logic nw,
                         input logic [31:0] nd, output int waited);
    int idx, e_acc, e_lat, lat, setup_n, acc_n, unstable, ready_hi, bad_sel;
    logic hit, e_err, got, o_err, idle_at_rsp;
    logic [NS-1:0] e_psel, psel_or;
    logic [31:0] e_rdata, o_rdata;
    logic [32:0] exp_rsp;
    // reference: decode, wait states and timeout decide the whole outcome
    idx = int'(a[15:12]);
    hit = (a[31:16] == BASE[31:16]) && (idx < NS);
    e_psel = '0; e_acc = 0; e_err = 1'b1; e_rdata = 32'd0;
    if (hit) begin
      e_psel[idx] = 1'b1;
      if (stuck[idx]) e_acc = TO;
      else begin
        e_acc = int'(wait_cfg[idx]) + 1;
        e_err = 1'b0;
        if (!w) e_rdata = prdata_v[idx];
      end
    end
    e_lat = hit ? e_acc + 2 : 1;
    exp_q.push_back({e_err, e_rdata});
    noise = NS'($urandom_range(0, (1 << NS) - 1));
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge PCLK);
      waited++;
    end
    chk("accept", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(negedge PCLK);
    req_valid = nv; req_addr = na; req_write = nw; req_wdata = nd;
    got = 1'b0; lat = 0; setup_n = 0; acc_n = 0; unstable = 0; ready_hi = 0; bad_sel = 0;
    psel_or = '0; o_rdata = '0; o_err = 1'b0; idle_at_rsp = 1'b0;
    for (int k = 1; k <= 60 && !got; k++) begin
      if (k > 1) @(negedge PCLK);
      if (PSEL != 0) begin
        psel_or |= PSEL;
        if ($countones(PSEL) != 1) bad_sel++;
        if (PENABLE) acc_n++; else setup_n++;
        if (PADDR !== a || PWRITE !== w || PWDATA !== d) unstable++;
      end else if (PENABLE) bad_sel++;
      if (req_ready) ready_hi++;
      if (rsp_valid) begin
        got = 1'b1; lat = k; o_rdata = rsp_rdata; o_err = rsp_err;
        idle_at_rsp = (PSEL == 0) && !PENABLE;
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(e_lat));
    chk("psel", 32'(psel_or), 32'(e_psel));
    chk("setup_cycles", 32'(setup_n), hit ? 32'd1 : 32'd0);
    chk("access_cycles", 32'(acc_n), 32'(e_acc));
    chk("bus_stable", 32'(unstable), 32'd0);
    chk("ready_busy", 32'(ready_hi), 32'd0);
    chk("sel_onehot", 32'(bad_sel), 32'd0);
    chk("idle_at_rsp", 32'(idle_at_rsp), 32'd1);
    exp_rsp = exp_q.pop_front();
    chk("rsp_err", 32'(o_err), 32'(exp_rsp[32]));
    chk("rsp_rdata", o_rdata, exp_rsp[31:0]);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog expired state=%0d checks=%0d", dbg_state, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int wt;
    PRESET = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    stuck = '0; noise = '0;
    for (int k = 0; k < NS; k++) begin
      wait_cfg[k] = 4'd1;
      prdata_v[k] = $urandom();
    end

    // reset values
    #12;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge PCLK); PRESET = 1'b1;
    @(negedge PCLK);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // 1: write to slave 0, ready on 2nd ACCESS cycle
    wait_cfg[0] = 4'd1;
    run_req(32'h1000_0008, 1'b1, 32'h0000_00A5, 1'b0, '0, 1'b0, '0, wt);

    // 2: read slave 2, other slaves drive all-ones
    for (int k = 0; k < NS; k++) prdata_v[k] = 32'hFFFF_FFFF;
    prdata_v[2] = 32'h0000_005A; wait_cfg[2] = 4'd1;
    run_req(32'h1000_2004, 1'b0, 32'h0, 1'b0, '0, 1'b0, '0, wt);

    // 3: decode misses (other window, index beyond NUM_SLAVES)
    run_req(32'h2000_0000, 1'b0, 32'h0, 1'b0, '0, 1'b0, '0, wt);
    run_req(32'h1000_7000, 1'b0, 32'h0, 1'b0, '0, 1'b0, '0, wt);

    // 4: slave 1 never ready -> timeout
    stuck[1] = 1'b1;
    run_req(32'h1000_1000, 1'b0, 32'h0, 1'b0, '0, 1'b0, '0, wt);
    @(negedge PCLK);
    chk("t4_idle_psel", 32'(PSEL), 32'd0);
    chk("t4_idle_penable", 32'(PENABLE), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd1);

    // 5: reset asserted in the middle of an ACCESS phase
    req_valid = 1'b1; req_addr = 32'h1000_1010; req_write = 1'b0;
    @(negedge PCLK); req_valid = 1'b0;
    @(negedge PCLK);
    chk("t5_in_access", 32'(PENABLE), 32'd1);
    #2 PRESET = 1'b0;
    #1;
    chk("t5_psel_async", 32'(PSEL), 32'd0);
    chk("t5_penable_async", 32'(PENABLE), 32'd0);
    chk("t5_rsp_async", 32'(rsp_valid), 32'd0);
    @(negedge PCLK);
    chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    PRESET = 1'b1; stuck[1] = 1'b0;
    @(negedge PCLK);
    chk("t5_ready_after", 32'(req_ready), 32'd1);
    chk("t5_paddr_cleared", PADDR, 32'd0);
    prdata_v[1] = 32'h1234_5678; wait_cfg[1] = 4'd1;
    run_req(32'h1000_1004, 1'b0, 32'h0, 1'b0, '0, 1'b0, '0, wt);

    // 6: three back-to-back writes with req_valid held high
    wait_cfg[0] = 4'd1; wait_cfg[1] = 4'd0; wait_cfg[3] = 4'd2;
    run_req(32'h1000_0010, 1'b1, 32'hAAAA_0001, 1'b1, 32'h1000_1020, 1'b1, 32'hBBBB_0002, wt);
    run_req(32'h1000_1020, 1'b1, 32'hBBBB_0002, 1'b1, 32'h1000_3030, 1'b1, 32'hCCCC_0003, wt);
    chk("t6_wait2", 32'(wt), 32'd1);
    run_req(32'h1000_3030, 1'b1, 32'hCCCC_0003, 1'b0, '0, 1'b0, '0, wt);
    chk("t6_wait3", 32'(wt), 32'd1);

    // random requests
    for (int i = 0; i < 24; i++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      for (int k = 0; k < NS; k++) begin
        wait_cfg[k] = 4'($urandom_range(0, 3));
        stuck[k]    = ($urandom_range(0, 7) == 0);
        prdata_v[k] = $urandom();
      end
      if (kind == 0)      a = {16'h2000 + 16'($urandom_range(0, 255)), 16'($urandom())};
      else if (kind == 1) a = {16'h1000, 4'($urandom_range(NS, 15)), 12'($urandom())};
      else                a = {16'h1000, 4'($urandom_range(0, NS - 1)), 12'($urandom())};
      run_req(a, 1'($urandom_range(0, 1)), $urandom(), 1'b0, '0, 1'b0, '0, wt);
    end

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
